// File: rtl/mips_muldiv_unit_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: opcodes, FSM states and
// the per-iteration mode selector used by the step datapath.
package mips_muldiv_unit_pkg;

  // Request opcodes presented on the op port
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Selects which iteration the step datapath performs
  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One combinational iteration of the multi-cycle datapath. The accumulator is a
// {acc_hi, acc_lo} pair:
//   multiply: acc_lo holds the not-yet-consumed multiplier bits; when its LSB is
//             set the multiplicand is added to acc_hi, then the pair shifts right.
//   divide:   acc_lo holds the not-yet-consumed dividend bits and collects the
//             quotient; the pair shifts left, a trial subtract of the divisor is
//             kept only when it does not go negative (restoring division).
module mips_muldiv_unit_step
  import mips_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_t       mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_shift_low;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;

  // Compute both candidate iterations and select by mode
  always_comb begin
    // Multiply: conditional add with one carry bit, then shift the pair right
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    // Divide: the shifted partial remainder is {acc_hi, acc_lo msb}. If the bit
    // shifted out of acc_hi is set, the remainder already exceeds any WIDTH-bit
    // divisor, so the subtract fits and its low WIDTH bits are exact.
    div_shift_low = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    div_fits      = acc_hi[WIDTH-1] | (div_shift_low >= operand);
    div_diff      = div_shift_low - operand;

    if (mode == MODE_MUL) begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      next_hi = div_fits ? div_diff : div_shift_low;
      next_lo = {acc_lo[WIDTH-2:0], div_fits};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MIPS32 multiply/divide unit. Operands are converted to magnitudes
// on accept, WIDTH iterations run on a private accumulator, and a final fix-up
// cycle applies signs and writes the architectural HI/LO registers. HI/LO are
// therefore untouched while an operation is in flight.
module mips_muldiv_unit
  import mips_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] step_reg;
  logic             is_div_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             b_zero_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg;
  logic             dbz_reg;

  logic             accept;
  logic             last_step;
  logic             req_is_div, req_is_signed;
  logic             req_sign_a, req_sign_b;
  logic [WIDTH-1:0] req_mag_a, req_mag_b;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_raw, prod_signed;
  logic [WIDTH-1:0] res_quot, res_rem;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign start_ready = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

  assign accept    = start_valid & start_ready;
  assign last_step = (step_reg == CNT_W'(WIDTH - 1));

  // Decode the incoming request into a mode, operand signs and magnitudes
  always_comb begin
    req_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    req_is_signed = (op == OP_MULT) || (op == OP_DIV);
    req_sign_a    = req_is_signed & a[WIDTH-1];
    req_sign_b    = req_is_signed & b[WIDTH-1];
    req_mag_a     = req_sign_a ? -a : a;
    req_mag_b     = req_sign_b ? -b : b;
  end

  mips_muldiv_unit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode    (is_div_reg ? MODE_DIV : MODE_MUL),
    .acc_hi  (acc_hi_reg),
    .acc_lo  (acc_lo_reg),
    .operand (opnd_reg),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Sign correction of the finished accumulator. With a zero divisor every
  // trial subtract succeeds, so the remainder path shifts the dividend
  // magnitude back out unchanged and its sign fix restores a as issued; only
  // the quotient needs forcing to all-ones.
  always_comb begin
    prod_raw    = {acc_hi_reg, acc_lo_reg};
    prod_signed = neg_q_reg ? -prod_raw : prod_raw;
    res_quot    = b_zero_reg ? '1 : (neg_q_reg ? -acc_lo_reg : acc_lo_reg);
    res_rem     = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    res_hi      = is_div_reg ? res_rem  : prod_signed[2*WIDTH-1:WIDTH];
    res_lo      = is_div_reg ? res_quot : prod_signed[WIDTH-1:0];
  end

  // Next-state logic: IDLE -> RUN for WIDTH steps -> FIX for one cycle -> IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: latch request, iterate, publish result, and MTHI/MTLO writes
  always_ff @(posedge clk) begin
    if (rst) begin
      step_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      opnd_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_FIX);
      case (state_reg)
        ST_IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (accept) begin
            step_reg   <= '0;
            is_div_reg <= req_is_div;
            neg_q_reg  <= req_sign_a ^ req_sign_b;
            neg_r_reg  <= req_sign_a;
            b_zero_reg <= (b == '0);
            dbz_reg    <= 1'b0;
            acc_hi_reg <= '0;
            // Multiply walks the multiplier through acc_lo; divide walks the dividend
            acc_lo_reg <= req_is_div ? req_mag_a : req_mag_b;
            opnd_reg   <= req_is_div ? req_mag_b : req_mag_a;
          end
        end
        ST_RUN: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          step_reg   <= step_reg + CNT_W'(1);
        end
        ST_FIX: begin
          hi_reg  <= res_hi;
          lo_reg  <= res_lo;
          dbz_reg <= is_div_reg & b_zero_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit. Inputs change 1 time unit after
// the rising edge and outputs are sampled at that same point.
module tb_mips_muldiv_unit;

  localparam int WIDTH = 32;
  localparam logic [1:0] T_MULT = 2'b00, T_MULTU = 2'b01, T_DIV = 2'b10, T_DIVU = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             hi_we, lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done. Reports edges from accept to
  // done, cycles with busy high, and whether hi/lo stayed put while busy.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, output int edges,
                        output int busy_cycles, output bit stable);
    logic [WIDTH-1:0] h0, l0;
    op = o; a = av; b = bv; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    h0 = hi; l0 = lo;
    edges = 0; busy_cycles = busy ? 1 : 0; stable = 1'b1;
    while (edges < 100) begin
      tick();
      edges++;
      if (busy) begin
        busy_cycles++;
        if (hi !== h0 || lo !== l0) stable = 1'b0;
      end
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", start_ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo); end
    $display("[TB] reset: busy=%b ready=%b hi=%h lo=%h", busy, start_ready, hi, lo);
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; wdata = 32'h1234_5678; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0; tick();
    lo_we = 1'b0;
    tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi: got %h expected 12345678", hi); end
    tests++; if (lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo: got %h expected 9abcdef0", lo); end
    $display("[TB] mthi/mtlo: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mult();
    int e, bc; bit st;
    run_op(T_MULT, 32'd7, 32'hFFFF_FFFD, e, bc, st);
    tests++; if (e !== 33) begin fails++; $display("FAIL mult_latency: got %0d expected 33", e); end
    tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL mult_stable: got %b expected 1", st); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL mult_dbz: got %b expected 0", div_by_zero); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    $display("[TB] MULT 7*-3: hi=%h lo=%h edges=%0d", hi, lo, e);
  endtask

  task automatic test_multu();
    int e, bc; bit st;
    run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, st);
    tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo); end
    tests++; if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL multu_stable: got %b expected 1", st); end
    $display("[TB] MULTU max*max: hi=%h lo=%h busy_cycles=%0d", hi, lo, bc);
  endtask

  task automatic test_div();
    int e, bc; bit st;
    run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, e, bc, st);
    tests++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_dividend: got lo=%h hi=%h expected fffffffd/ffffffff", lo, hi); end
    tests++; if (e !== 33) begin fails++; $display("FAIL div_latency: got %0d expected 33", e); end
    $display("[TB] DIV -7/2: lo=%h hi=%h", lo, hi);
    run_op(T_DIV, 32'd7, 32'hFFFF_FFFE, e, bc, st);
    tests++; if (lo !== 32'hFFFF_FFFD || hi !== 32'h0000_0001) begin fails++; $display("FAIL div_neg_divisor: got lo=%h hi=%h expected fffffffd/00000001", lo, hi); end
    $display("[TB] DIV 7/-2: lo=%h hi=%h", lo, hi);
    run_op(T_DIVU, 32'd100, 32'd7, e, bc, st);
    tests++; if (lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL divu_basic: got lo=%h hi=%h expected 0000000e/00000002", lo, hi); end
    $display("[TB] DIVU 100/7: lo=%h hi=%h", lo, hi);
    run_op(T_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, e, bc, st);
    tests++; if (lo !== 32'h0000_FFFF || hi !== 32'h0000_FFFF) begin fails++; $display("FAIL divu_large: got lo=%h hi=%h expected 0000ffff/0000ffff", lo, hi); end
    $display("[TB] DIVU ffffffff/10000: lo=%h hi=%h", lo, hi);
  endtask

  task automatic test_div_overflow();
    int e, bc; bit st;
    run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, st);
    tests++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin fails++; $display("FAIL div_overflow: got lo=%h hi=%h expected 80000000/00000000", lo, hi); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL div_overflow_dbz: got %b expected 0", div_by_zero); end
    $display("[TB] DIV 80000000/-1: lo=%h hi=%h dbz=%b", lo, hi, div_by_zero);
  endtask

  task automatic test_div_by_zero();
    int e, bc; bit st;
    run_op(T_DIVU, 32'd100, 32'd0, e, bc, st);
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL divu_zero_flag: got %b expected 1", div_by_zero); end
    tests++; if (hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_zero_result: got hi=%h lo=%h expected 00000064/ffffffff", hi, lo); end
    tests++; if (e !== 33) begin fails++; $display("FAIL divu_zero_latency: got %0d expected 33", e); end
    $display("[TB] DIVU 100/0: hi=%h lo=%h dbz=%b edges=%0d", hi, lo, div_by_zero, e);
    tick();
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_held: got %b expected 1", div_by_zero); end
    run_op(T_DIV, 32'hFFFF_FFFB, 32'd0, e, bc, st);
    tests++; if (hi !== 32'hFFFF_FFFB || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin fails++; $display("FAIL div_zero_signed: got hi=%h lo=%h dbz=%b expected fffffffb/ffffffff/1", hi, lo, div_by_zero); end
    $display("[TB] DIV -5/0: hi=%h lo=%h dbz=%b", hi, lo, div_by_zero);
    // Flag must clear on the next accept, not at its done
    op = T_MULTU; a = 32'd2; b = 32'd3; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_clear_on_accept: got %b expected 0", div_by_zero); end
    for (int i = 0; i < 100 && !done; i++) tick();
    tests++; if (lo !== 32'd6) begin fails++; $display("FAIL dbz_followup: got %h expected 00000006", lo); end
    $display("[TB] dbz clear + MULTU 2*3: lo=%h", lo);
  endtask

  task automatic test_back_to_back();
    int n;
    bit ready_seen;
    op = T_MULTU; a = 32'd6; b = 32'd7; start_valid = 1'b1;
    tick();
    // Second request held continuously while the first runs
    a = 32'd9; b = 32'd11;
    ready_seen = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (start_ready) ready_seen = 1'b1;
      tick();
      n++;
    end
    tests++; if (ready_seen !== 1'b0) begin fails++; $display("FAIL hold_ready_low: got ready_seen=%b expected 0", ready_seen); end
    tests++; if (lo !== 32'd42 || done !== 1'b1) begin fails++; $display("FAIL hold_first: got lo=%h done=%b expected 0000002a/1", lo, done); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL hold_ready_at_done: got %b expected 1", start_ready); end
    tick();
    start_valid = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL hold_second_taken: got busy=%b done=%b expected 1/0", busy, done); end
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    tests++; if (lo !== 32'd99 || hi !== 32'd0) begin fails++; $display("FAIL hold_second: got lo=%h hi=%h expected 00000063/00000000", lo, hi); end
    $display("[TB] back-to-back MULTU 6*7 then 9*11: lo=%h", lo);
  endtask

  task automatic test_reset_mid_op();
    int e, bc; bit st;
    bit done_seen;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A; tick();
    hi_we = 1'b0; lo_we = 1'b0;
    op = T_MULTU; a = 32'h0000_FFFF; b = 32'h0000_FFFF; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen = 1'b1;
      tick();
    end
    tests++; if (done_seen !== 1'b0) begin fails++; $display("FAIL reset_no_done: got %b expected 0", done_seen); end
    run_op(T_MULTU, 32'd3, 32'd5, e, bc, st);
    tests++; if (lo !== 32'd15 || hi !== 32'd0) begin fails++; $display("FAIL after_reset_mult: got lo=%h hi=%h expected 0000000f/00000000", lo, hi); end
    $display("[TB] reset at step 10, then MULTU 3*5: lo=%h", lo);
  endtask

  task automatic test_mtlo_while_busy();
    int n;
    // MTLO on the accept edge lands; MTLO during RUN is dropped
    op = T_MULTU; a = 32'd2; b = 32'd4; start_valid = 1'b1;
    lo_we = 1'b1; wdata = 32'hCAFE_BABE;
    tick();
    start_valid = 1'b0; lo_we = 1'b0;
    tests++; if (lo !== 32'hCAFE_BABE || busy !== 1'b1) begin fails++; $display("FAIL same_edge_mtlo: got lo=%h busy=%b expected cafebabe/1", lo, busy); end
    repeat (5) tick();
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0000_DEAD;
    tick();
    lo_we = 1'b0; hi_we = 1'b0;
    tests++; if (lo !== 32'hCAFE_BABE) begin fails++; $display("FAIL mtlo_busy_ignored: got %h expected cafebabe", lo); end
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    tests++; if (lo !== 32'd8 || hi !== 32'd0) begin fails++; $display("FAIL mtlo_overwritten: got lo=%h hi=%h expected 00000008/00000000", lo, hi); end
    $display("[TB] MTLO same-edge/busy then MULTU 2*4: lo=%h", lo);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_mtlo_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
